// File: rtl/csr_access_pkg.sv
// Shared definitions for the CSR access controller: op encodings, FSM states
// and the address pattern that marks a CSR as read-only.
package csr_access_pkg;

    localparam int CSR_ADDR_W = 12;
    localparam int CSR_DATA_W = 32;

    typedef enum logic [1:0] {
        CSR_OP_RSVD = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESPOND
    } csr_state_e;

    // Addresses whose top two bits are both set belong to the read-only space.
    localparam logic [CSR_ADDR_W-1:0] CSR_RO_MASK = 12'hC00;

    function automatic logic isReadOnlyAddr(input logic [CSR_ADDR_W-1:0] addr);
        return (addr & CSR_RO_MASK) == CSR_RO_MASK;
    endfunction

endpackage

// File: rtl/csr_access_controller_if.sv
// Pipeline request/response handshake plus the CSR register-file bus.
// The slave modport is the controller's view; master is the environment's.
interface csr_access_controller_if;
    import csr_access_pkg::*;

    logic                  reqValid;
    logic                  reqReady;
    logic [1:0]            reqOp;
    logic [CSR_ADDR_W-1:0] reqAddress;
    logic [CSR_DATA_W-1:0] reqOperand;
    logic                  reqReadSuppress;
    logic                  reqWriteSuppress;

    logic                  respValid;
    logic                  respReady;
    logic [CSR_DATA_W-1:0] respData;
    logic                  respIllegal;

    logic                  csrReadEnable;
    logic                  csrWriteEnable;
    logic [CSR_ADDR_W-1:0] csrReadAddress;
    logic [CSR_ADDR_W-1:0] csrWriteAddress;
    logic [CSR_DATA_W-1:0] csrWriteData;
    logic [CSR_DATA_W-1:0] csrReadData;
    logic                  csrRequestOutput;

    modport slave (
        input  reqValid, reqOp, reqAddress, reqOperand, reqReadSuppress, reqWriteSuppress,
        input  respReady, csrReadData, csrRequestOutput,
        output reqReady, respValid, respData, respIllegal,
        output csrReadEnable, csrWriteEnable, csrReadAddress, csrWriteAddress, csrWriteData
    );

    modport master (
        output reqValid, reqOp, reqAddress, reqOperand, reqReadSuppress, reqWriteSuppress,
        output respReady, csrReadData, csrRequestOutput,
        input  reqReady, respValid, respData, respIllegal,
        input  csrReadEnable, csrWriteEnable, csrReadAddress, csrWriteAddress, csrWriteData
    );

endinterface

// File: rtl/csr_access_alu.sv
// Computes the value written back to a CSR from the op, the old value and
// the source operand. Purely combinational.
module csr_access_alu
    import csr_access_pkg::*;
(
    input  csr_op_e               i_op,
    input  logic [CSR_DATA_W-1:0] i_oldValue,
    input  logic [CSR_DATA_W-1:0] i_operand,
    output logic [CSR_DATA_W-1:0] o_newValue
);

    always_comb begin
        o_newValue = '0;
        unique case (i_op)
            CSR_OP_RW: o_newValue = i_operand;
            CSR_OP_RS: o_newValue = i_oldValue | i_operand;
            CSR_OP_RC: o_newValue = i_oldValue & ~i_operand;
            default:   o_newValue = '0;
        endcase
    end

endmodule

// File: rtl/csr_access_controller.sv
// Sequences one CSR instruction at a time through read, modify and write of
// the register file, then holds the old value and illegal flag until consumed.
module csr_access_controller
    import csr_access_pkg::*;
#(
    parameter bit READ_ONLY_CHECK = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    csr_access_controller_if.slave bus
);

    csr_state_e            r_state;
    csr_state_e            w_nextState;
    csr_op_e               r_op;
    csr_op_e               w_reqOp;
    logic [CSR_ADDR_W-1:0] r_address;
    logic [CSR_DATA_W-1:0] r_operand;
    logic [CSR_DATA_W-1:0] r_oldData;
    logic [CSR_DATA_W-1:0] w_newValue;
    logic                  r_doWrite;
    logic                  r_illegal;
    logic                  w_accept;
    logic                  w_isReserved;
    logic                  w_writeSkip;
    logic                  w_roViolation;

    assign w_reqOp      = csr_op_e'(bus.reqOp);
    assign w_accept     = (r_state == ST_IDLE) && bus.reqValid;
    assign w_isReserved = (w_reqOp == CSR_OP_RSVD);
    assign w_writeSkip  = ((w_reqOp == CSR_OP_RS) || (w_reqOp == CSR_OP_RC)) && bus.reqWriteSuppress;

    // Write legality is settled at accept time so the write enable later
    // depends only on registered state.
    assign w_roViolation = READ_ONLY_CHECK && isReadOnlyAddr(bus.reqAddress)
                           && !w_writeSkip && !w_isReserved;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState        = r_state;
        bus.reqReady       = 1'b0;
        bus.respValid      = 1'b0;
        bus.respData       = '0;
        bus.respIllegal    = 1'b0;
        bus.csrReadEnable  = 1'b0;
        bus.csrWriteEnable = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                bus.reqReady = rst;
                if (bus.reqValid) begin
                    if (w_isReserved) begin
                        w_nextState = ST_RESPOND;
                    end else if (bus.reqReadSuppress) begin
                        w_nextState = ST_WRITE;
                    end else begin
                        w_nextState = ST_READ;
                    end
                end
            end
            ST_READ: begin
                bus.csrReadEnable = 1'b1;
                w_nextState       = bus.csrRequestOutput ? ST_WRITE : ST_RESPOND;
            end
            ST_WRITE: begin
                bus.csrWriteEnable = r_doWrite;
                w_nextState        = ST_RESPOND;
            end
            ST_RESPOND: begin
                bus.respValid   = 1'b1;
                bus.respData    = r_oldData;
                bus.respIllegal = r_illegal;
                if (bus.respReady) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Old data is cleared on accept so a skipped read reports zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op      <= CSR_OP_RSVD;
            r_address <= '0;
            r_operand <= '0;
            r_oldData <= '0;
            r_doWrite <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op      <= w_reqOp;
                r_address <= bus.reqAddress;
                r_operand <= bus.reqOperand;
                r_oldData <= '0;
                r_doWrite <= !w_isReserved && !w_writeSkip && !w_roViolation;
                r_illegal <= w_isReserved || w_roViolation;
            end
            if (r_state == ST_READ) begin
                r_oldData <= bus.csrReadData;
                if (!bus.csrRequestOutput) begin
                    r_illegal <= 1'b1;
                end
            end
        end
    end

    csr_access_alu u_alu (
        .i_op       (r_op),
        .i_oldValue (r_oldData),
        .i_operand  (r_operand),
        .o_newValue (w_newValue)
    );

    assign bus.csrReadAddress  = r_address;
    assign bus.csrWriteAddress = r_address;
    assign bus.csrWriteData    = w_newValue;

endmodule

// File: tb/tb_csr_access_controller.sv
// Self-checking bench: fixed vectors, randomized transactions against a
// spec-level model, and hand sequences for stall and reset-abort.
module tb_csr_access_controller;
    import csr_access_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] operand;
        logic        rsup;
        logic        wsup;
        logic [31:0] expData;
        logic        expIllegal;
        logic        expWrite;
        logic [31:0] expWdata;
        int          expLat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    csr_access_controller_if bus ();

    csr_access_controller #(.READ_ONLY_CHECK(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] regMem [0:4095];
    logic [31:0] shadow [0:4095];
    bit          mapped [0:4095];

    assign bus.csrRequestOutput = bus.csrReadEnable && mapped[bus.csrReadAddress];
    assign bus.csrReadData      = bus.csrRequestOutput ? regMem[bus.csrReadAddress] : 32'h0;

    int          checks = 0;
    int          errors = 0;
    int          cycleCnt = 0;
    int          writeCount = 0;
    int          readCount = 0;
    int          lastWriteCycle = 0;
    int          lastReadCycle = 0;
    int          oneHotViolations = 0;
    logic [11:0] lastWriteAddr = '0;
    logic [31:0] lastWriteData = '0;

    // Register-file side: commits writes at the clock edge and logs bus activity.
    always @(posedge clk) begin
        if (bus.csrReadEnable && bus.csrWriteEnable) begin
            oneHotViolations <= oneHotViolations + 1;
        end
        if (bus.csrReadEnable) begin
            readCount     <= readCount + 1;
            lastReadCycle <= cycleCnt;
        end
        if (bus.csrWriteEnable) begin
            writeCount     <= writeCount + 1;
            lastWriteCycle <= cycleCnt;
            lastWriteAddr  <= bus.csrWriteAddress;
            lastWriteData  <= bus.csrWriteData;
            if (mapped[bus.csrWriteAddress]) begin
                regMem[bus.csrWriteAddress] <= bus.csrWriteData;
            end
        end
        cycleCnt <= cycleCnt + 1;
    end

    logic [31:0] obsData;
    logic        obsIllegal;
    logic [11:0] obsWaddr;
    logic [31:0] obsWdata;
    int          obsLat;
    int          obsWrites;
    int          obsReads;
    int          obsWriteRel;
    int          obsReadRel;
    bit          gotResp;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Spec-level prediction; advances the shadow register image when a write is due.
    function automatic vec_t modelPredict(input vec_t v);
        vec_t        r;
        logic [31:0] old;
        bit          wantsWrite;
        r            = v;
        r.expData    = 32'h0;
        r.expIllegal = 1'b0;
        r.expWrite   = 1'b0;
        r.expWdata   = 32'h0;
        if (v.op == 2'b00) begin
            r.expIllegal = 1'b1;
            r.expLat     = 1;
            return r;
        end
        if (v.rsup) begin
            old = 32'h0;
        end else if (!mapped[v.addr]) begin
            r.expIllegal = 1'b1;
            r.expLat     = 2;
            return r;
        end else begin
            old = shadow[v.addr];
        end
        r.expData  = old;
        r.expLat   = v.rsup ? 2 : 3;
        wantsWrite = !((v.op != 2'b01) && v.wsup);
        if (wantsWrite && (v.addr[11:10] == 2'b11)) begin
            r.expIllegal = 1'b1;
        end else if (wantsWrite) begin
            r.expWrite = 1'b1;
            case (v.op)
                2'b01:   r.expWdata = v.operand;
                2'b10:   r.expWdata = old | v.operand;
                default: r.expWdata = old & ~v.operand;
            endcase
            if (mapped[v.addr]) begin
                shadow[v.addr] = r.expWdata;
            end
        end
        return r;
    endfunction

    task automatic applyStimulus(input vec_t v, input bit holdResp);
        int startCycle;
        int startWrites;
        int startReads;
        @(negedge clk);
        checkOutput("reqReadyIdle", {31'b0, bus.reqReady}, 32'd1);
        bus.reqValid         = 1'b1;
        bus.reqOp            = v.op;
        bus.reqAddress       = v.addr;
        bus.reqOperand       = v.operand;
        bus.reqReadSuppress  = v.rsup;
        bus.reqWriteSuppress = v.wsup;
        bus.respReady        = !holdResp;
        startCycle           = cycleCnt;
        startWrites          = writeCount;
        startReads           = readCount;
        @(posedge clk);
        #1;
        bus.reqValid   = 1'b0;
        bus.reqOperand = $urandom;
        gotResp        = 1'b0;
        for (int i = 0; i < 20 && !gotResp; i++) begin
            @(negedge clk);
            if (bus.respValid) begin
                gotResp    = 1'b1;
                obsData    = bus.respData;
                obsIllegal = bus.respIllegal;
                obsLat     = cycleCnt - startCycle;
            end
        end
        if (!gotResp) begin
            checks++;
            errors++;
            $display("[TB] FAIL respTimeout: got no respValid in 20 cycles, expected one");
        end
        obsWrites   = writeCount - startWrites;
        obsReads    = readCount - startReads;
        obsWriteRel = lastWriteCycle - startCycle;
        obsReadRel  = lastReadCycle - startCycle;
        obsWaddr    = lastWriteAddr;
        obsWdata    = lastWriteData;
    endtask

    task automatic checkTxn(input string tag, input vec_t v);
        int expReads;
        expReads = ((v.op != 2'b00) && !v.rsup) ? 1 : 0;
        checkOutput({tag, ".data"}, obsData, v.expData);
        checkOutput({tag, ".illegal"}, {31'b0, obsIllegal}, {31'b0, v.expIllegal});
        checkOutput({tag, ".latency"}, 32'(obsLat), 32'(v.expLat));
        checkOutput({tag, ".writes"}, 32'(obsWrites), v.expWrite ? 32'd1 : 32'd0);
        checkOutput({tag, ".reads"}, 32'(obsReads), 32'(expReads));
        if (v.expWrite) begin
            checkOutput({tag, ".wdata"}, obsWdata, v.expWdata);
            checkOutput({tag, ".waddr"}, {20'b0, obsWaddr}, {20'b0, v.addr});
            checkOutput({tag, ".wcycle"}, 32'(obsWriteRel), 32'(v.expLat - 1));
        end
        if (expReads == 1) begin
            checkOutput({tag, ".rcycle"}, 32'(obsReadRel), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [11:0] addrPool [0:6];
    vec_t        vecTable [0:9];
    vec_t        v;
    int          startWrites;

    initial begin
        bus.reqValid         = 1'b0;
        bus.reqOp            = 2'b00;
        bus.reqAddress       = '0;
        bus.reqOperand       = '0;
        bus.reqReadSuppress  = 1'b0;
        bus.reqWriteSuppress = 1'b0;
        bus.respReady        = 1'b1;

        for (int i = 0; i < 4096; i++) begin
            regMem[i] <= 32'h0;
            shadow[i] = 32'h0;
            mapped[i] = 1'b0;
        end
        addrPool = '{12'h340, 12'h300, 12'h305, 12'h7C0, 12'hC00, 12'hC01, 12'h341};
        mapped[12'h340] = 1'b1; regMem[12'h340] <= 32'h12345678; shadow[12'h340] = 32'h12345678;
        mapped[12'h300] = 1'b1; regMem[12'h300] <= 32'h00000003; shadow[12'h300] = 32'h00000003;
        mapped[12'h305] = 1'b1; regMem[12'h305] <= 32'h80000000; shadow[12'h305] = 32'h80000000;
        mapped[12'hC00] = 1'b1; regMem[12'hC00] <= 32'hAAAA0000; shadow[12'hC00] = 32'hAAAA0000;
        mapped[12'hC01] = 1'b1; regMem[12'hC01] <= 32'h0000FFFF; shadow[12'hC01] = 32'h0000FFFF;
        mapped[12'h341] = 1'b1; regMem[12'h341] <= 32'h00000100; shadow[12'h341] = 32'h00000100;

        //                 op     addr     operand       rs  ws  expData       ill wr  expWdata      lat
        vecTable[0] = '{2'b01, 12'h340, 32'hDEADBEEF, 0, 0, 32'h12345678, 0, 1, 32'hDEADBEEF, 3};
        vecTable[1] = '{2'b10, 12'h300, 32'h00000008, 0, 0, 32'h00000003, 0, 1, 32'h0000000B, 3};
        vecTable[2] = '{2'b11, 12'h300, 32'h00000001, 0, 0, 32'h0000000B, 0, 1, 32'h0000000A, 3};
        vecTable[3] = '{2'b01, 12'h7C0, 32'h00000123, 0, 0, 32'h00000000, 1, 0, 32'h00000000, 2};
        vecTable[4] = '{2'b01, 12'hC00, 32'h00000005, 0, 0, 32'hAAAA0000, 1, 0, 32'h00000000, 3};
        vecTable[5] = '{2'b10, 12'hC00, 32'h00000000, 0, 1, 32'hAAAA0000, 0, 0, 32'h00000000, 3};
        vecTable[6] = '{2'b00, 12'h340, 32'h0000FFFF, 0, 0, 32'h00000000, 1, 0, 32'h00000000, 1};
        vecTable[7] = '{2'b01, 12'h340, 32'h00000055, 1, 0, 32'h00000000, 0, 1, 32'h00000055, 2};
        vecTable[8] = '{2'b11, 12'h340, 32'h00000000, 0, 1, 32'h00000055, 0, 0, 32'h00000000, 3};
        vecTable[9] = '{2'b10, 12'h340, 32'h000000F0, 0, 0, 32'h00000055, 0, 1, 32'h000000F5, 3};

        #1;
        checkOutput("rstReqReady", {31'b0, bus.reqReady}, 32'd0);
        checkOutput("rstCtl", {27'b0, bus.respValid, bus.respIllegal, bus.csrReadEnable,
                               bus.csrWriteEnable, bus.reqReady}, 32'd0);
        checkOutput("rstData", bus.respData | bus.csrWriteData, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("postRstReqReady", {31'b0, bus.reqReady}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            v = modelPredict(vecTable[i]);
            applyStimulus(vecTable[i], 1'b0);
            checkTxn($sformatf("vec%0d", i), vecTable[i]);
        end

        for (int i = 0; i < 40; i++) begin
            v.op      = 2'($urandom_range(0, 3));
            v.addr    = addrPool[$urandom_range(0, 6)];
            v.operand = $urandom;
            v.rsup    = (v.op == 2'b01) && ($urandom_range(0, 3) == 0);
            v.wsup    = (v.op[1] == 1'b1) && ($urandom_range(0, 2) == 0);
            v = modelPredict(v);
            applyStimulus(v, 1'b0);
            checkTxn($sformatf("rnd%0d", i), v);
        end

        // Consumer stalls: response must stay put and no new request may enter.
        v.op = 2'b10; v.addr = 12'h305; v.operand = 32'h00000011; v.rsup = 1'b0; v.wsup = 1'b0;
        v = modelPredict(v);
        applyStimulus(v, 1'b1);
        checkTxn("stall", v);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("stall%0d.valid", i), {31'b0, bus.respValid}, 32'd1);
            checkOutput($sformatf("stall%0d.data", i), bus.respData, v.expData);
            checkOutput($sformatf("stall%0d.illegal", i), {31'b0, bus.respIllegal}, 32'd0);
            checkOutput($sformatf("stall%0d.reqReady", i), {31'b0, bus.reqReady}, 32'd0);
        end
        bus.respReady = 1'b1;
        @(negedge clk);
        checkOutput("stallRelease.valid", {31'b0, bus.respValid}, 32'd0);
        checkOutput("stallRelease.reqReady", {31'b0, bus.reqReady}, 32'd1);

        // Reset lands while the controller sits in WRITE with an enable pending.
        bus.reqValid        = 1'b1;
        bus.reqOp           = 2'b01;
        bus.reqAddress      = 12'h341;
        bus.reqOperand      = 32'h00000999;
        bus.reqReadSuppress = 1'b0;
        bus.reqWriteSuppress = 1'b0;
        startWrites         = writeCount;
        @(posedge clk);
        #1;
        bus.reqValid = 1'b0;
        @(negedge clk);
        checkOutput("abort.readEn", {31'b0, bus.csrReadEnable}, 32'd1);
        @(negedge clk);
        checkOutput("abort.writeEnBefore", {31'b0, bus.csrWriteEnable}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("abort.ctl", {27'b0, bus.respValid, bus.respIllegal, bus.csrReadEnable,
                                  bus.csrWriteEnable, bus.reqReady}, 32'd0);
        checkOutput("abort.addr", {8'b0, bus.csrReadAddress, bus.csrWriteAddress}, 32'd0);
        checkOutput("abort.data", bus.respData | bus.csrWriteData, 32'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort.noWrite", 32'(writeCount - startWrites), 32'd0);
        checkOutput("abort.regKept", regMem[12'h341], shadow[12'h341]);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort.idleReady", {31'b0, bus.reqReady}, 32'd1);
        checkOutput("abort.noResp", {31'b0, bus.respValid}, 32'd0);

        v.op = 2'b10; v.addr = 12'h341; v.operand = 32'h00000001; v.rsup = 1'b0; v.wsup = 1'b0;
        v = modelPredict(v);
        applyStimulus(v, 1'b0);
        checkTxn("afterAbort", v);

        checkOutput("enableOneHot", 32'(oneHotViolations), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
